uart_tx_buf: RTL and testbench

Buffered UART transmitter: serializes bytes onto `tx` as start, data (LSB first), optional parity and stop bits, all timed by the shared 16x oversampling `s_tick` from the baud-rate generator. It sits between a CPU/peripheral byte source and the serial pin, and is the transmit counterpart of the existing UART receiver on the same tick. A one-byte holding register behind a valid/ready handshake lets a second byte queue during a frame, so back-to-back frames have no idle gap.

---
 rtl/uart_tx_buf.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_buf.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: one-byte holding register feeding a start/data/parity/stop
// serializer paced by the shared 16x oversampling tick.
module uart_tx_buf #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic [7:0] din,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick,
  output logic       bit_tick
);

  // state  | meaning
  // IDLE   | line high, waiting for the holding register to fill
  // START  | start bit (low) for 16 ticks
  // DATA   | DBIT data bits, LSB first, 16 ticks each
  // PARITY | parity bit for 16 ticks
  // STOP   | stop period of SB_TICK ticks, may chain straight into the next START
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [4:0] S_LAST    = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
  localparam logic       PAR_INIT  = 1'(PARITY_ODD);

  state_t      state_reg, state_next;
  logic [4:0]  s_reg, s_next;
  logic [2:0]  n_reg, n_next;
  logic [7:0]  b_reg, b_next;
  logic [7:0]  hold_reg, hold_next;
  logic        hold_full, hold_full_next;
  logic        par_reg, par_next;
  logic        tx_reg, tx_next;
  logic        load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      hold_reg  <= hold_next;
      hold_full <= hold_full_next;
      par_reg   <= par_next;
      tx_reg    <= tx_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    s_next         = s_reg;
    n_next         = n_reg;
    b_next         = b_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full;
    par_next       = par_reg;
    tx_next        = tx_reg;
    tx_done_tick   = 1'b0;
    bit_tick       = 1'b0;
    load           = 1'b0;

    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (hold_full) load = 1'b1;
      end
      START: begin
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            bit_tick   = 1'b1;
            s_next     = '0;
            n_next     = '0;
            tx_next    = b_reg[0];
            state_next = DATA;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            bit_tick = 1'b1;
            s_next   = '0;
            par_next = par_reg ^ b_reg[0];
            b_next   = {1'b0, b_reg[7:1]};
            if (n_reg == N_LAST) begin
              if (PARITY_EN != 0) begin
                tx_next    = par_reg ^ b_reg[0];
                state_next = PARITY;
              end else begin
                tx_next    = 1'b1;
                state_next = STOP;
              end
            end else begin
              n_next  = n_reg + 3'd1;
              tx_next = b_reg[1];
            end
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            bit_tick   = 1'b1;
            s_next     = '0;
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_reg == STOP_LAST) begin
            tx_done_tick = 1'b1;
            bit_tick     = 1'b1;
            s_next       = '0;
            if (hold_full) begin
              load = 1'b1;
            end else begin
              tx_next    = 1'b1;
              state_next = IDLE;
            end
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Reload from idle or straight out of the stop period so frames abut.
    if (load) begin
      b_next         = hold_reg;
      hold_full_next = 1'b0;
      par_next       = PAR_INIT;
      s_next         = '0;
      tx_next        = 1'b0;
      state_next     = START;
    end

    // Accept and reload are mutually exclusive: reload needs hold_full, accept needs ~hold_full.
    if (tx_valid && tx_ready) begin
      hold_next      = din;
      hold_full_next = 1'b1;
    end
  end

  assign tx_ready = ~hold_full;
  assign tx       = tx_reg;
  assign tx_busy  = (state_reg != IDLE) | hold_full;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: four parameterisations checked every cycle against a frame-position
// model, plus hand-computed slot patterns and timing literals.
module tb_uart_tx_buf;

  localparam int PE [4] = '{0, 1, 1, 0};
  localparam int PO [4] = '{0, 0, 1, 0};
  localparam int SB [4] = '{16, 16, 16, 32};

  logic       clk, reset, s_tick, pause;
  logic [7:0] din;
  logic [3:0] valid;
  logic [3:0] tx_w, rdy_w, busy_w, done_w, bt_w;

  int total = 0;
  int bad = 0;
  int nprint = 0;
  int tcnt = 0;
  int bt_cnt0 = 0;
  int done_cnt0 = 0;

  uart_tx_buf #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .din(din), .tx_valid(valid[0]),
    .tx_ready(rdy_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]),
    .bit_tick(bt_w[0]));
  uart_tx_buf #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .din(din), .tx_valid(valid[1]),
    .tx_ready(rdy_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done_tick(done_w[1]),
    .bit_tick(bt_w[1]));
  uart_tx_buf #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .din(din), .tx_valid(valid[2]),
    .tx_ready(rdy_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done_tick(done_w[2]),
    .bit_tick(bt_w[2]));
  uart_tx_buf #(.DBIT(8), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0)) u3 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .din(din), .tx_valid(valid[3]),
    .tx_ready(rdy_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done_tick(done_w[3]),
    .bit_tick(bt_w[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // s_tick every 4th clock unless paused
  initial begin
    s_tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (pause) s_tick = 1'b0;
      else if (tcnt == 3) begin s_tick = 1'b1; tcnt = 0; end
      else begin s_tick = 1'b0; tcnt++; end
    end
  end

  // Model: a frame is a list of slots (start, 8 data, optional parity, stop) indexed by
  // ticks elapsed since the frame began.
  bit         in_f [4];
  bit         hf [4];
  int         pos [4];
  logic [7:0] cur [4];
  logic [7:0] hb [4];

  function automatic int nb(input int i);
    return 9 + PE[i];
  endfunction

  function automatic int ft(input int i);
    return 16 * nb(i) + SB[i];
  endfunction

  function automatic logic frame_bit(input int i, input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (slot == 9 && PE[i] != 0) return (^b) ^ (PO[i] != 0);
    return 1'b1;
  endfunction

  function automatic logic [4:0] model_out(input int i);
    int p, slot;
    logic last, btk;
    if (!in_f[i]) return {1'b1, ~hf[i], hf[i], 1'b0, 1'b0};
    p    = pos[i];
    slot = (p < 16 * nb(i)) ? p / 16 : nb(i);
    last = s_tick && (p == ft(i) - 1);
    btk  = last || (s_tick && p < 16 * nb(i) && (p % 16) == 15);
    return {frame_bit(i, cur[i], slot), ~hf[i], 1'b1, last, btk};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        in_f[i] = 1'b0; hf[i] = 1'b0; pos[i] = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        bit acc;
        acc = valid[i] && !hf[i];
        if (in_f[i]) begin
          if (s_tick) begin
            if (pos[i] == ft(i) - 1) begin
              if (hf[i]) begin cur[i] = hb[i]; pos[i] = 0; hf[i] = 1'b0; end
              else in_f[i] = 1'b0;
            end else pos[i]++;
          end
        end else if (hf[i]) begin
          in_f[i] = 1'b1; cur[i] = hb[i]; pos[i] = 0; hf[i] = 1'b0;
        end
        if (acc) begin hb[i] = din; hf[i] = 1'b1; end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      logic [4:0] act, exp;
      act = {tx_w[i], rdy_w[i], busy_w[i], done_w[i], bt_w[i]};
      exp = model_out(i);
      total++;
      if (act !== exp) begin
        bad++;
        if (nprint < 30) begin
          nprint++;
          $display("FAIL model u%0d t=%0t tx/rdy/busy/done/bit got %b want %b", i, $time, act, exp);
        end
      end
    end
    if (done_w[0]) done_cnt0++;
    if (bt_w[0]) bt_cnt0++;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic send(input int i, input logic [7:0] b);
    int g;
    g = 0;
    din = b;
    valid[i] = 1'b1;
    while (rdy_w[i] !== 1'b1 && g < 3000) begin @(posedge clk); #1; g++; end
    if (g >= 3000) begin total++; bad++; $display("FAIL send u%0d timeout", i); end
    @(posedge clk); #1;
    valid[i] = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int c, g;
    c = 0; g = 0;
    while (c < n && g < 20000) begin @(posedge clk); if (s_tick) c++; g++; end
  endtask

  task automatic capture(input int i, input int nslots, output logic [15:0] bits);
    int n;
    bits = '0;
    n = 0;
    while (tx_w[i] !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) begin total++; bad++; $display("FAIL capture u%0d start bit timeout", i); end
    for (int k = 0; k < nslots; k++) begin
      wait_ticks(k == 0 ? 8 : 16);
      @(negedge clk);
      bits[k] = tx_w[i];
    end
  endtask

  task automatic wait_idle(input int i);
    int g;
    g = 0;
    while (busy_w[i] !== 1'b0 && g < 5000) begin @(negedge clk); g++; end
    if (g >= 5000) begin total++; bad++; $display("FAIL idle u%0d timeout", i); end
  endtask

  initial begin
    logic [15:0] bits;
    int bt0, dn0, cnt, g;
    logic t0;
    reset = 1'b1; pause = 1'b0; din = '0; valid = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx", 16'(tx_w[0]), 16'h1);
    check("reset_ready", 16'(rdy_w[0]), 16'h1);
    check("reset_busy", 16'(busy_w[0]), 16'h0);
    check("reset_done", 16'(done_w[0]), 16'h0);
    check("reset_bit_tick", 16'(bt_w[0]), 16'h0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (5) @(posedge clk); #1;

    // 0xA5, default frame, plus accept latency
    bt0 = bt_cnt0; dn0 = done_cnt0;
    send(0, 8'hA5);
    check("accept_ready_low", 16'(rdy_w[0]), 16'h0);
    check("accept_tx_still_high", 16'(tx_w[0]), 16'h1);
    @(posedge clk); #1;
    check("start_tx_low", 16'(tx_w[0]), 16'h0);
    check("start_ready_back", 16'(rdy_w[0]), 16'h1);
    capture(0, 10, bits);
    check("slots_A5", bits, 16'h034A);
    wait_idle(0);
    check("bit_tick_count_A5", 16'(bt_cnt0 - bt0), 16'd10);
    check("done_count_A5", 16'(done_cnt0 - dn0), 16'd1);

    // parity, even then odd
    send(1, 8'h07);
    capture(1, 11, bits);
    check("slots_07_even", bits, 16'h060E);
    wait_idle(1);
    send(2, 8'h07);
    capture(2, 11, bits);
    check("slots_07_odd", bits, 16'h040E);
    wait_idle(2);

    // reset during data bit 3
    send(0, 8'h00);
    capture(0, 5, bits);
    check("pre_reset_tx_low", 16'(bits[4]), 16'h0);
    #2 reset = 1'b1;
    #1;
    check("async_reset_tx", 16'(tx_w[0]), 16'h1);
    check("async_reset_busy", 16'(busy_w[0]), 16'h0);
    check("async_reset_ready", 16'(rdy_w[0]), 16'h1);
    repeat (2) @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    send(0, 8'h3C);
    capture(0, 10, bits);
    check("slots_3C_after_reset", bits, 16'h0278);
    wait_idle(0);

    // three frames back to back, third byte held while the holding register is full
    send(0, 8'h00);
    fork
      begin
        send(0, 8'hFF);
        check("queued_ready_low", 16'(rdy_w[0]), 16'h0);
        send(0, 8'h5A);
      end
      begin
        int k, gap, gg;
        k = 0; gap = 0; gg = 0;
        while (k < 3 && gg < 5000) begin
          @(negedge clk); gg++;
          if (done_w[0]) k++;
          if (!busy_w[0]) gap++;
        end
        check("b2b_frames_done", 16'(k), 16'd3);
        check("b2b_idle_cycles", 16'(gap), 16'd0);
      end
    join
    wait_idle(0);

    // SB_TICK=32 with a 100-clock tick stall mid-frame
    send(3, 8'h3C);
    repeat (200) @(posedge clk);
    @(negedge clk); pause = 1'b1;
    @(posedge clk); #2;
    t0 = tx_w[3];
    cnt = 0;
    for (int c = 0; c < 99; c++) begin
      @(negedge clk);
      if (tx_w[3] !== t0) cnt++;
    end
    check("pause_tx_frozen_changes", 16'(cnt), 16'd0);
    pause = 1'b0;
    cnt = 0; g = 0;
    while (g < 5000) begin
      @(negedge clk); g++;
      if (done_w[3]) begin cnt++; break; end
      else if (bt_w[3]) cnt = 0;
      else if (s_tick) cnt++;
    end
    check("stop_ticks_sb32", 16'(cnt), 16'd32);
    wait_idle(3);

    repeat (10) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
